// File: rtl/replica_exchange_sched.sv
`default_nettype none
// ============================================================================
//  Module   : replica_exchange_sched
//  Purpose  : Replica-exchange scheduler for the parallel-tempering salesman
//             engine. Each sweep pairs adjacent-temperature replicas with an
//             even or odd start and makes a Metropolis decision per pair. It
//             then streams one exchange command per replica, in ascending id
//             order, to the replica nodes.
//  Revision : 1.0 - initial release
// ============================================================================
module replica_exchange_sched #(
    parameter int REPLICA_NUM = 160,
    parameter int ID_W        = $clog2(REPLICA_NUM),
    parameter int TOTAL_W     = 23,
    parameter int RND_W       = 24,
    parameter int DBETA       = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    output logic                    busy,
    output logic                    done,
    output logic                    e_rd_en,
    output logic [ID_W-1:0]         e_rd_addr,
    input  logic [TOTAL_W-1:0]      e_rd_data,
    input  logic                    rnd_valid,
    output logic                    rnd_ready,
    input  logic signed [RND_W-1:0] rnd_data,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [ID_W-1:0]         cmd_id,
    output logic [1:0]              cmd,
    output logic [ID_W-1:0]         accept_cnt
);

    // Command encoding seen by the replica nodes
    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_SELF = 2'd1,
        CMD_PREV = 2'd2,
        CMD_FOLW = 2'd3
    } exchange_command_t;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_RD_A   = 4'd1,
        S_RD_B   = 4'd2,
        S_LAT_B  = 4'd3,
        S_RND    = 4'd4,
        S_DEC    = 4'd5,
        S_EMIT_A = 4'd6,
        S_EMIT_B = 4'd7,
        S_EMIT_S = 4'd8,
        S_FIN    = 4'd9
    } state_t;

    // idx must be able to hold REPLICA_NUM itself (end-of-sweep marker)
    localparam int IDX_W = ID_W + 1;
    // Decision sum width: sign-extended difference times DBETA plus ln(r)
    localparam int SW    = TOTAL_W + 1 + $clog2(DBETA + 1) + 1;

    localparam logic [IDX_W-1:0]     C_N     = IDX_W'(REPLICA_NUM);
    localparam logic [IDX_W-1:0]     C_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0]     C_TWO   = IDX_W'(2);
    localparam logic [ID_W-1:0]      C_CNT1  = ID_W'(1);
    localparam logic signed [SW-1:0] C_DBETA = SW'(DBETA);

    state_t                    state_r;
    state_t                    state_nx;
    state_t                    w_after_emit;
    logic [IDX_W-1:0]          idx_r;
    logic [TOTAL_W-1:0]        ea_r;
    logic [TOTAL_W-1:0]        eb_r;
    logic signed [RND_W-1:0]   rnd_r;
    logic                      acc_r;
    logic [ID_W-1:0]           cnt_r;
    logic [1:0]                mode_r;
    logic                      par_r;

    logic [IDX_W-1:0]          w_idx_p1;
    logic [IDX_W-1:0]          w_idx_p2;
    logic                      w_start_odd;
    logic signed [TOTAL_W:0]   w_d;
    logic signed [SW-1:0]      w_d_ext;
    logic signed [SW-1:0]      w_rnd_ext;
    logic signed [SW-1:0]      w_s;
    logic                      w_accept;

    assign w_idx_p1 = idx_r + C_ONE;
    assign w_idx_p2 = idx_r + C_TWO;

    // Parity chosen for a sweep: mode0 alternates, mode1 even, mode2 odd
    assign w_start_odd = (mode == 2'd0) ? par_r : (mode == 2'd2);

    // Metropolis decision: accept when (Ea-Eb)*DBETA + ln(r) >= 0
    always_comb begin
        w_d       = $signed({1'b0, ea_r}) - $signed({1'b0, eb_r});
        w_d_ext   = {{(SW-TOTAL_W-1){w_d[TOTAL_W]}}, w_d};
        w_rnd_ext = {{(SW-RND_W){rnd_r[RND_W-1]}}, rnd_r};
        w_s       = (w_d_ext * C_DBETA) + w_rnd_ext;
        w_accept  = ~w_s[SW-1];
    end

    // Where to go after a command handshake, based on the post-advance index
    always_comb begin
        w_after_emit = S_EMIT_S;
        if (w_idx_p1 == C_N) begin
            w_after_emit = S_FIN;
        end else if ((w_idx_p2 < C_N) && (mode_r != 2'd3)) begin
            w_after_emit = S_RD_A;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nx  = state_r;
        busy      = 1'b0;
        done      = 1'b0;
        e_rd_en   = 1'b0;
        e_rd_addr = '0;
        rnd_ready = 1'b0;
        cmd_valid = 1'b0;
        cmd_id    = '0;
        cmd       = CMD_NOP;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx = ((mode == 2'd3) || w_start_odd) ? S_EMIT_S : S_RD_A;
                end
            end
            S_RD_A: begin
                busy      = 1'b1;
                e_rd_en   = 1'b1;
                e_rd_addr = idx_r[ID_W-1:0];
                state_nx  = S_RD_B;
            end
            S_RD_B: begin
                busy      = 1'b1;
                e_rd_en   = 1'b1;
                e_rd_addr = w_idx_p1[ID_W-1:0];
                state_nx  = S_LAT_B;
            end
            S_LAT_B: begin
                busy     = 1'b1;
                state_nx = S_RND;
            end
            S_RND: begin
                busy      = 1'b1;
                rnd_ready = 1'b1;
                if (rnd_valid) begin
                    state_nx = S_DEC;
                end
            end
            S_DEC: begin
                busy     = 1'b1;
                state_nx = S_EMIT_A;
            end
            S_EMIT_A: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                cmd_id    = idx_r[ID_W-1:0];
                cmd       = acc_r ? CMD_FOLW : CMD_SELF;
                if (cmd_ready) begin
                    state_nx = S_EMIT_B;
                end
            end
            S_EMIT_B: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                cmd_id    = idx_r[ID_W-1:0];
                cmd       = acc_r ? CMD_PREV : CMD_SELF;
                if (cmd_ready) begin
                    state_nx = w_after_emit;
                end
            end
            S_EMIT_S: begin
                busy      = 1'b1;
                cmd_valid = 1'b1;
                cmd_id    = idx_r[ID_W-1:0];
                cmd       = CMD_SELF;
                if (cmd_ready) begin
                    state_nx = w_after_emit;
                end
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Sweep datapath: index, captured energies/random, decision and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r      <= '0;
            ea_r       <= '0;
            eb_r       <= '0;
            rnd_r      <= '0;
            acc_r      <= 1'b0;
            cnt_r      <= '0;
            mode_r     <= 2'd0;
            par_r      <= 1'b0;
            accept_cnt <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        idx_r  <= '0;
                        cnt_r  <= '0;
                    end
                end
                S_RD_B: begin
                    ea_r <= e_rd_data;
                end
                S_LAT_B: begin
                    eb_r <= e_rd_data;
                end
                S_RND: begin
                    if (rnd_valid) begin
                        rnd_r <= rnd_data;
                    end
                end
                S_DEC: begin
                    acc_r <= w_accept;
                end
                S_EMIT_A: begin
                    if (cmd_ready) begin
                        idx_r <= w_idx_p1;
                        if (acc_r) begin
                            cnt_r <= cnt_r + C_CNT1;
                        end
                    end
                end
                S_EMIT_B, S_EMIT_S: begin
                    if (cmd_ready) begin
                        idx_r <= w_idx_p1;
                    end
                end
                S_FIN: begin
                    accept_cnt <= cnt_r;
                    if (mode_r == 2'd0) begin
                        par_r <= ~par_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_replica_exchange_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_replica_exchange_sched
//  Purpose  : Self-checking bench for replica_exchange_sched (5 replicas).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_replica_exchange_sched;

    localparam int N   = 5;
    localparam int IDW = $clog2(N);
    localparam int TW  = 23;
    localparam int RW  = 24;
    localparam int DB  = 5;
    localparam int FX  = 131072;

    localparam logic [1:0] K_NOP  = 2'd0;
    localparam logic [1:0] K_SELF = 2'd1;
    localparam logic [1:0] K_PREV = 2'd2;
    localparam logic [1:0] K_FOLW = 2'd3;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [1:0]           mode;
    logic                 busy;
    logic                 done;
    logic                 e_rd_en;
    logic [IDW-1:0]       e_rd_addr;
    logic [TW-1:0]        e_rd_data;
    logic                 rnd_valid;
    logic                 rnd_ready;
    logic signed [RW-1:0] rnd_data;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [IDW-1:0]       cmd_id;
    logic [1:0]           cmd;
    logic [IDW-1:0]       accept_cnt;

    replica_exchange_sched #(
        .REPLICA_NUM (N),
        .ID_W        (IDW),
        .TOTAL_W     (TW),
        .RND_W       (RW),
        .DBETA       (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .e_rd_en    (e_rd_en),
        .e_rd_addr  (e_rd_addr),
        .e_rd_data  (e_rd_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_id     (cmd_id),
        .cmd        (cmd),
        .accept_cnt (accept_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Energy memory: data valid one cycle after the read strobe
    logic [TW-1:0] mem [N];
    always @(posedge clk) begin
        if (e_rd_en && (int'(e_rd_addr) < N)) e_rd_data <= mem[e_rd_addr];
    end

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [1:0]     c;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [1:0] mode;
        int e0, e1, e2, e3, e4;
        int rnd;
        int acc;
        int hs;
    } vec_t;
    vec_t vecs[10];

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int stall_lim = 0, stall_used = 0;
    int hold_lim = 0, hold_used = 0;
    logic [IDW-1:0] stall_id = '0;
    bit exp_par = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [1:0] c);
        exp_t e;
        e.id = IDW'(id);
        e.c  = c;
        sb_q.push_back(e);
    endtask

    // Reference pairing and Metropolis model
    task automatic push_model(input logic [1:0] m, input bit p, input int r);
        int i;
        longint s;
        bit a;
        if (m == 2'd3) begin
            for (int k = 0; k < N; k++) push_exp(k, K_SELF);
        end else begin
            i = 0;
            if (p) begin
                push_exp(0, K_SELF);
                i = 1;
            end
            while (i < N) begin
                if (i + 1 < N) begin
                    s = (longint'(mem[i]) - longint'(mem[i+1])) * DB + longint'(r);
                    a = (s >= 0);
                    push_exp(i,     a ? K_FOLW : K_SELF);
                    push_exp(i + 1, a ? K_PREV : K_SELF);
                    i += 2;
                end else begin
                    push_exp(i, K_SELF);
                    i += 1;
                end
            end
        end
    endtask

    task automatic load(input vec_t v);
        mem[0] = TW'(v.e0); mem[1] = TW'(v.e1); mem[2] = TW'(v.e2);
        mem[3] = TW'(v.e3); mem[4] = TW'(v.e4);
        rnd_data = RW'(v.rnd);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_done"},      done, 0);
        chk({tag, "_e_rd_en"},   e_rd_en, 0);
        chk({tag, "_e_rd_addr"}, e_rd_addr, 0);
        chk({tag, "_rnd_ready"}, rnd_ready, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_id"},    cmd_id, 0);
        chk({tag, "_cmd"},       cmd, K_NOP);
        chk({tag, "_accept_cnt"}, accept_cnt, 0);
    endtask

    task automatic run_sweep(input vec_t v, input bit poke_busy, input bit poke_fin);
        bit p;
        bit seen;
        int hs0;
        load(v);
        p = (v.mode == 2'd0) ? exp_par : (v.mode == 2'd2);
        push_model(v.mode, p, v.rnd);
        hs0 = hs_cnt;
        @(negedge clk);
        mode  = v.mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = ~v.mode;
        chk("busy_after_start", busy, 1);
        if (poke_busy) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            mode  = 2'd3;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        if (poke_fin) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("accept_cnt", accept_cnt, v.acc);
        chk("rnd_handshakes", hs_cnt - hs0, v.hs);
        chk("sb_leftover", sb_q.size(), 0);
        if (v.mode == 2'd0) exp_par = ~exp_par;
        sb_q.delete();
    endtask

    // Handshake driver and scoreboard checker, sampling on the falling edge
    initial begin
        cmd_ready = 1'b1;
        rnd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cmd_valid && (stall_used < stall_lim) && (cmd_id == stall_id)) begin
                    cmd_ready = 1'b0;
                    stall_used++;
                    if (sb_q.size() > 0) begin
                        chk("stall_cmd_id", cmd_id, sb_q[0].id);
                        chk("stall_cmd", cmd, sb_q[0].c);
                    end
                end else begin
                    cmd_ready = 1'b1;
                end
                if (rnd_ready && (hold_used < hold_lim)) begin
                    rnd_valid = 1'b0;
                    hold_used++;
                    chk("rnd_wait_no_cmd", cmd_valid, 0);
                end else begin
                    rnd_valid = 1'b1;
                end
                if (rnd_valid && rnd_ready) hs_cnt++;
                if (cmd_valid && cmd_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_cmd: got id %0d cmd %0d expected none", cmd_id, cmd);
                    end else begin
                        chk("cmd_id", cmd_id, sb_q[0].id);
                        chk("cmd", cmd, sb_q[0].c);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit cv;
        vecs[0] = '{2'd1, 10*FX, 20*FX, 30*FX, 25*FX, 40*FX, 0, 1, 2};
        vecs[1] = '{2'd2, 10*FX, 20*FX, 30*FX, 25*FX, 40*FX, 0, 0, 2};
        vecs[2] = '{2'd1, 0, FX, 1, 0, 0, -5, 1, 2};
        vecs[3] = '{2'd1, 0, FX, 1, 0, 0, -6, 0, 2};
        vecs[4] = '{2'd1, 0, FX, 5, 5, 0, 0, 1, 2};
        vecs[5] = '{2'd3, 10*FX, 20*FX, 30*FX, 25*FX, 40*FX, 0, 0, 0};
        vecs[6] = '{2'd0, 50*FX, 40*FX, 30*FX, 20*FX, 10*FX, 0, 2, 2};
        vecs[7] = '{2'd0, 50*FX, 40*FX, 30*FX, 20*FX, 10*FX, 0, 2, 2};
        vecs[8] = '{2'd0, 50*FX, 40*FX, 30*FX, 20*FX, 10*FX, 0, 2, 2};
        vecs[9] = '{2'd1, 50*FX, 40*FX, 30*FX, 20*FX, 10*FX, -60*FX, 0, 2};

        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 2'd0;
        rnd_data = '0;
        for (int k = 0; k < N; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_sweep(vecs[i], (i == 1), (i == 5));
        end

        // Backpressure on the second command of pair (0,1) and a slow random source
        stall_id  = IDW'(1);
        stall_lim = stall_used + 7;
        hold_lim  = hold_used + 10;
        run_sweep(vecs[0], 1'b0, 1'b0);
        chk("stall_cycles_applied", stall_lim - stall_used, 0);
        chk("rnd_hold_cycles_applied", hold_lim - hold_used, 0);

        // Asynchronous reset while the first command is presented
        load(vecs[0]);
        push_model(2'd1, 1'b0, 0);
        @(negedge clk);
        mode  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cv = 1'b0;
        for (int c = 0; c < 100 && !cv; c++) begin
            if (cmd_valid) cv = 1'b1;
            else @(negedge clk);
        end
        chk("reached_emit_a", cv, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb_q.delete();
        exp_par = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(vecs[0], 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
